// File: rtl/id_hazard_sched.sv
// id_hazard_sched: RAW hazard detection, memory freeze/abort sequencing and
// saturating stall statistics for the five-stage pipeline, beside ID.
// Optional build macro: ID_HAZARD_FORWARDING_EN (only a load in EXE stalls).
module id_hazard_sched #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             hazard,
  output logic             freeze_if,
  output logic             freeze,
  output logic             flush,
  output logic             mem_abort,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int unsigned TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ABORT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               mem_err_q, mem_err_d;
  logic               mem_abort_q, mem_abort_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic m1_c, m2_c, raw_c;
  logic freeze_c, hazard_c, flush_c;

  // Register matching between the ID operands and the pending writers.
  always_comb begin
    m1_c = (exe_wb_en && (exe_dest == src1)) || (mem_wb_en && (mem_dest == src1));
    m2_c = two_src && ((exe_wb_en && (exe_dest == src2)) || (mem_wb_en && (mem_dest == src2)));
  end

`ifdef ID_HAZARD_FORWARDING_EN
  // With forwarding only a load still in EXE cannot supply its result in time.
  logic unused_match;
  assign unused_match = m1_c | m2_c;
  assign raw_c = exe_mem_r_en && exe_wb_en &&
                 ((exe_dest == src1) || (two_src && (exe_dest == src2)));
`else
  // Without forwarding any pending writer in EXE or MEM stalls.
  logic unused_load;
  assign unused_load = exe_mem_r_en;
  assign raw_c = m1_c | m2_c;
`endif

  // Memory FSM next state, timeout tracking and freeze decode.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    mem_err_d   = mem_err_q;
    freeze_c    = 1'b0;
    case (state_q)
      S_RUN: begin
        freeze_c = mem_req && !mem_ready;
        if (freeze_c) begin
          state_d = S_MEM_WAIT;
          tmr_d   = TMR_W'(1);
        end
      end
      S_MEM_WAIT: begin
        freeze_c = !mem_ready;
        if (mem_ready) begin
          state_d = S_RUN;
        end else if (tmr_q == TMR_W'(MEM_TIMEOUT - 1)) begin
          state_d   = S_ABORT;
          mem_err_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_ABORT: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    mem_abort_d = (state_d == S_ABORT);
  end

  // Stall/flush decode: a taken branch kills the ID instruction, a freeze defers both.
  always_comb begin
    flush_c  = branch_taken && !freeze_c;
    hazard_c = raw_c && !branch_taken && !freeze_c;
  end

  // Saturating statistics; clear takes priority over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      wait_cnt_d  = '0;
    end else begin
      if (hazard_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (freeze_c && !(&wait_cnt_q))  wait_cnt_d  = wait_cnt_q + CNT_W'(1);
    end
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      tmr_q       <= '0;
      mem_err_q   <= 1'b0;
      mem_abort_q <= 1'b0;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      mem_err_q   <= mem_err_d;
      mem_abort_q <= mem_abort_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // All outputs are held low while reset is asserted, even before the first edge.
  assign hazard    = rst & hazard_c;
  assign freeze    = rst & freeze_c;
  assign freeze_if = rst & (hazard_c | freeze_c);
  assign flush     = rst & flush_c;
  assign mem_abort = rst & mem_abort_q;
  assign mem_err   = rst & mem_err_q;
  assign stall_cnt = {CNT_W{rst}} & stall_cnt_q;
  assign wait_cnt  = {CNT_W{rst}} & wait_cnt_q;

endmodule

// File: doc/id_hazard_sched.md
# id_hazard_sched

Pipeline hazard and stall scheduler for the five-stage ARM pipeline, sitting beside the ID stage. It detects read-after-write hazards between the instruction in ID and the instructions in EXE and MEM, and drives the ID `hazard` input that zeroes the control bundle. It also sequences multi-cycle data-memory accesses through a freeze/abort state machine, and keeps saturating stall statistics.

## Interface
- `MEM_TIMEOUT`, 16: maximum cycles spent in MEM_WAIT before abort (≥2).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, synchronous, active-low.
- `src1` in 4: Rn of the ID instruction.
- `src2` in 4: Rm or Rd (store) of the ID instruction.
- `two_src` in 1: `src2` is a real operand.
- `exe_wb_en` in 1: EXE instruction writes the register file.
- `exe_dest` in 4: EXE destination.
- `exe_mem_r_en` in 1: EXE instruction is a load.
- `mem_wb_en` in 1: MEM instruction writes the register file.
- `mem_dest` in 4: MEM destination.
- `branch_taken` in 1: EXE B bit.
- `mem_req` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `clr_cnt` in 1: synchronous clear of the counters.
- `hazard` out 1: to ID; forces control to zero.
- `freeze_if` out 1: hold PC and the IF/ID register.
- `freeze` out 1: hold all pipeline registers.
- `flush` out 1: clear IF/ID and ID/EXE.
- `mem_abort` out 1: one-cycle pulse telling memory to drop the access.
- `mem_err` out 1: sticky timeout flag.
- `stall_cnt` out CNT_W: count of hazard cycles.
- `wait_cnt` out CNT_W: count of freeze cycles.

## Operation
Register matching:
- `m1 = (exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1)`.
- `m2` is the same comparison for `src2`, ANDed with `two_src`.
- `raw` is defined in Configuration.

Combinational outputs:
- `flush = branch_taken & ~freeze`.
- `hazard = raw & ~branch_taken & ~freeze`. A branch in EXE kills the wrong-path instruction in ID, so no stall is raised for it.
- `freeze_if = hazard | freeze`.
- While `rst`=0, every output is forced to 0.

State machine (states RUN, MEM_WAIT, ABORT; reset state RUN):
- **RUN**
  - `freeze = mem_req & ~mem_ready`.
  - If `freeze`=1: next state MEM_WAIT, `tmr` <= 1.
- **MEM_WAIT**
  - `freeze = ~mem_ready`.
  - If `mem_ready`=1: next state RUN.
  - Else if `tmr == MEM_TIMEOUT-1`: next state ABORT and `mem_err` <= 1.
  - Else `tmr` <= `tmr+1`.
- **ABORT**
  - `freeze`=0 and `mem_abort`=1; `mem_req` is ignored.
  - Next state RUN.

Other rules:
- `mem_abort` is 0 outside ABORT.
- `mem_err` clears only on reset.
- Counters:
  - Registered and saturating at all-ones.
  - `stall_cnt` increments on cycles with `hazard`=1.
  - `wait_cnt` increments on cycles with `freeze`=1.
  - `clr_cnt`=1 loads 0; clear wins over increment in the same cycle.

## Timing
- `hazard`, `flush`, `freeze`, `freeze_if`: zero-latency combinational, from inputs and the current state.
- `mem_abort`: registered; decoded from state.
- A load-use hazard holds `hazard`=1 for exactly one cycle with FORWARDING_EN, because the load moves to MEM on the next edge.
- Without FORWARDING_EN, `hazard` holds up to two cycles (EXE match, then MEM match).
- Memory wait: `freeze` rises in the same cycle as `mem_req` & ~`mem_ready`. It stays high through the cycle before `mem_ready`, and is 0 in the cycle where `mem_ready`=1.
- `mem_ready`=1 on the timeout cycle: ready wins, no abort, no `mem_err`.
- `mem_req` with `mem_ready`=1 in RUN: no freeze, and the state stays RUN.
- `branch_taken` while frozen: `flush` is deferred until the first unfrozen cycle; `branch_taken` is held by the frozen pipeline registers.
- Reset asserted in MEM_WAIT: the next state is RUN, `tmr` is cleared, and all outputs are 0 while `rst`=0.
- Counter values are observed one cycle after the event.

## Configuration
- `ID_HAZARD_FORWARDING_EN`
  - Defined: EXE and MEM results are forwarded, so only a load in EXE stalls. `raw = exe_mem_r_en & exe_wb_en & ((exe_dest==src1) | (two_src & exe_dest==src2))`.
  - Undefined: `raw = m1 | m2`, meaning any pending writer in EXE or MEM stalls.

## Test plan
- **No forwarding, EXE writer**: `exe_wb_en`=1, `exe_dest`=3, `src1`=3 -> `hazard`=1, `freeze_if`=1, `stall_cnt` 0->1. Then `src2`=3 with `two_src`=0 -> `hazard`=0.
- **Forwarding, load-use vs ALU**:
  - `exe_mem_r_en`=1, `exe_wb_en`=1, `exe_dest`=5, `src2`=5, `two_src`=1 -> `hazard`=1 for one cycle.
  - The same case with `exe_mem_r_en`=0 -> `hazard`=0.
- **Branch priority**: `branch_taken`=1 together with a RAW match -> `flush`=1, `hazard`=0.
- **Memory wait**: `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1 -> `freeze` high for 3 cycles and low on the ready cycle, `wait_cnt`=3, state back in RUN.
- **Timeout**: `MEM_TIMEOUT`=4 and `mem_ready` held at 0 -> `freeze` high for 4 cycles, then `mem_abort`=1 for one cycle, `mem_err`=1 sticky, then RUN.
- **Reset and clear**:
  - `rst`=0 asserted mid-MEM_WAIT -> all outputs 0, RUN on release.
  - `clr_cnt`=1 coinciding with a hazard -> `stall_cnt`=0.
